// File: rtl/weight_bank_memory_pkg.sv
// rtl/weight_bank_memory_pkg.sv - FSM state encodings and index-width helper for weight_bank_memory
package weight_bank_memory_pkg;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_LOAD = 2'd1,
      WB_READ = 2'd2
   } wb_state_t;

   // Index width that never collapses to zero bits for a single-entry range.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/weight_rd_seq.sv
// rtl/weight_rd_seq.sv - replay sequencer: address/issue counters and the registered valid/last stage
module weight_rd_seq
   import weight_bank_memory_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = idx_bits(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  ready,
   output logic                  ren,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic                  valid,
   output logic                  last,
   output logic                  done
);

   localparam int CNT_WIDTH = $clog2(DEPTH + 1);
   localparam logic [CNT_WIDTH-1:0]  ISSUE_MAX = CNT_WIDTH'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = ADDR_WIDTH'(DEPTH - 1);

   logic                 active;
   logic [CNT_WIDTH-1:0] issued;
   logic                 advance;
   logic                 pending;

   assign advance = !valid || ready;
   assign pending = (issued != ISSUE_MAX);
   assign ren     = active && advance && pending;
   assign done    = valid && ready && last;

   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         issued <= '0;
         raddr  <= '0;
         valid  <= 1'b0;
         last   <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
         issued <= '0;
         raddr  <= '0;
         valid  <= 1'b0;
         last   <= 1'b0;
      end else if (active && advance) begin
         if (pending) begin
            valid  <= 1'b1;
            last   <= (raddr == ADDR_MAX);
            issued <= issued + CNT_WIDTH'(1);
            if (raddr != ADDR_MAX)
               raddr <= raddr + ADDR_WIDTH'(1);
         end else begin
            // Final beat has just been accepted; the burst is over.
            valid  <= 1'b0;
            last   <= 1'b0;
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/weight_bank_memory.sv
// rtl/weight_bank_memory.sv - multi-lane weight store: lane-major stream load, per-address burst replay
module weight_bank_memory
   import weight_bank_memory_pkg::*;
#(
   parameter int NUM_BANKS  = 4,
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 16,
   parameter     WEIGHT_FILE = "w_all.mif",
   parameter logic [DEPTH*NUM_BANKS*DATA_WIDTH-1:0] WEIGHT_INIT = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ld_start,
   input  logic                            ld_valid,
   input  logic [DATA_WIDTH-1:0]           ld_data,
   output logic                            ld_ready,
   output logic                            ld_done,
   input  logic                            rd_start,
   input  logic                            rd_ready,
   output logic                            rd_valid,
   output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
   output logic                            rd_last,
   output logic                            busy
);

   localparam int ADDR_WIDTH = idx_bits(DEPTH);
   localparam int ROW_WIDTH  = NUM_BANKS * DATA_WIDTH;

   wb_state_t             state;
   wb_state_t             state_next;
   logic [ROW_WIDTH-1:0]  mem [DEPTH];
   logic                  seq_start;
   logic                  seq_ren;
   logic                  seq_done;
   logic [ADDR_WIDTH-1:0] raddr;
   logic                  rd_go;

   assign busy  = (state != WB_IDLE);
   assign rd_go = rd_start && ld_done;

   always_ff @(posedge clk) begin
      if (rst)
         state <= WB_IDLE;
      else
         state <= state_next;
   end

`ifdef WEIGHT_PRELOAD_EN
   initial begin
      for (int a = 0; a < DEPTH; a++)
         mem[a] = WEIGHT_INIT[a*ROW_WIDTH +: ROW_WIDTH];
   end

   assign ld_ready = 1'b0;
   assign ld_done  = 1'b1;

   always_comb begin
      state_next = state;
      seq_start  = 1'b0;
      case (state)
         WB_IDLE: if (rd_go) begin
            state_next = WB_READ;
            seq_start  = 1'b1;
         end
         WB_READ: if (seq_done) state_next = WB_IDLE;
         default: state_next = WB_IDLE;
      endcase
   end
`else
   localparam int LANE_WIDTH = idx_bits(NUM_BANKS);
   localparam logic [LANE_WIDTH-1:0] LANE_MAX = LANE_WIDTH'(NUM_BANKS - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);

   logic [LANE_WIDTH-1:0] wlane;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  ld_fire;
   logic                  ld_final;

   // A restart pulse takes priority over a beat presented in the same cycle.
   assign ld_ready = (state == WB_LOAD);
   assign ld_fire  = ld_ready && ld_valid && !ld_start;
   assign ld_final = ld_fire && (wlane == LANE_MAX) && (waddr == ADDR_MAX);

   always_comb begin
      state_next = state;
      seq_start  = 1'b0;
      case (state)
         WB_IDLE: begin
            if (ld_start) begin
               state_next = WB_LOAD;
            end else if (rd_go) begin
               state_next = WB_READ;
               seq_start  = 1'b1;
            end
         end
         WB_LOAD: if (ld_final) state_next = WB_IDLE;
         WB_READ: if (seq_done) state_next = WB_IDLE;
         default: state_next = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wlane   <= '0;
         waddr   <= '0;
         ld_done <= 1'b0;
      end else if (ld_start && (state != WB_READ)) begin
         wlane   <= '0;
         waddr   <= '0;
         ld_done <= 1'b0;
      end else if (ld_fire) begin
         if (waddr == ADDR_MAX) begin
            waddr <= '0;
            if (wlane != LANE_MAX)
               wlane <= wlane + LANE_WIDTH'(1);
         end else begin
            waddr <= waddr + ADDR_WIDTH'(1);
         end
         if (ld_final)
            ld_done <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ld_fire)
         mem[waddr][int'(wlane)*DATA_WIDTH +: DATA_WIDTH] <= ld_data;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst)
         rd_data <= '0;
      else if (seq_ren)
         rd_data <= mem[raddr];
   end

   weight_rd_seq #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rd_seq (
      .clk   (clk),
      .rst   (rst),
      .start (seq_start),
      .ready (rd_ready),
      .ren   (seq_ren),
      .raddr (raddr),
      .valid (rd_valid),
      .last  (rd_last),
      .done  (seq_done)
   );

endmodule

// File: tb/tb_weight_bank_memory.sv
// tb/tb_weight_bank_memory.sv - scoreboard bench for weight_bank_memory (RAM build)
module tb_weight_bank_memory;

   localparam int NB    = 4;
   localparam int D     = 8;
   localparam int DW    = 16;
   localparam int RW    = NB * DW;
   localparam int BEATS = NB * D;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_start;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          ld_done;
   logic          rd_start;
   logic          rd_ready;
   logic          rd_valid;
   logic [RW-1:0] rd_data;
   logic          rd_last;
   logic          busy;

   typedef struct {
      logic [RW-1:0] data;
      logic          last;
   } beat_t;

   beat_t         exp_q[$];
   logic [DW-1:0] img   [BEATS];
   logic [DW-1:0] ref_w [NB][D];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   weight_bank_memory #(
      .NUM_BANKS  (NB),
      .DEPTH      (D),
      .DATA_WIDTH (DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ld_start (ld_start),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_ready (ld_ready),
      .ld_done  (ld_done),
      .rd_start (rd_start),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_last  (rd_last),
      .busy     (busy)
   );

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented beat must match the scoreboard head; pop on handshake.
   always @(negedge clk) begin
      if (!rst && rd_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat", rd_data);
         end else begin
            check("rd_data", rd_data, exp_q[0].data);
            check("rd_last", RW'(rd_last), RW'(exp_q[0].last));
            if (rd_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic do_load(input bit rand_data);
      int k   = 0;
      int cyc = 0;
      bit acc;
      for (int i = 0; i < BEATS; i++)
         img[i] = rand_data ? DW'($urandom) : DW'(i);
      ld_valid = 1'b0;
      ld_start = 1'b1;
      tick;
      ld_start = 1'b0;
      check("load_busy", RW'(busy), 1);
      check("load_ready", RW'(ld_ready), 1);
      check("load_done_cleared", RW'(ld_done), 0);
      while (k < BEATS && cyc < 1000) begin
         ld_valid = ($urandom_range(0, 2) != 0);
         ld_data  = img[k];
         acc      = ld_valid && ld_ready;
         tick;
         cyc++;
         if (acc) begin
            ref_w[k / D][k % D] = img[k];
            k++;
         end
      end
      ld_valid = 1'b0;
      if (k < BEATS) begin
         checks++;
         errors++;
         $display("FAIL load_timeout: got %0d beats expected %0d", k, BEATS);
      end
      check("ld_done_after_last", RW'(ld_done), 1);
      check("ld_ready_after_last", RW'(ld_ready), 0);
      check("busy_after_load", RW'(busy), 0);
      tick;
      check("ld_ready_stays_low", RW'(ld_ready), 0);
   endtask

   task automatic do_replay(input int stall_at, input int stall_len, input int abort_at, input bit rand_ready);
      int acc_n      = 0;
      int cyc        = 0;
      int stall_left = stall_len;
      bit acc;
      for (int a = 0; a < D; a++) begin
         beat_t b;
         for (int l = 0; l < NB; l++)
            b.data[l*DW +: DW] = ref_w[l][a];
         b.last = (a == D - 1);
         exp_q.push_back(b);
      end
      rd_ready = 1'b1;
      rd_start = 1'b1;
      tick;
      rd_start = 1'b0;
      check("replay_busy", RW'(busy), 1);
      check("replay_cycle1_idle", RW'(rd_valid), 0);
      tick;
      check("replay_cycle2_valid", RW'(rd_valid), 1);
      while (acc_n < D && cyc < 500) begin
         if (abort_at == acc_n) begin
            rst = 1'b1;
            tick;
            rst = 1'b0;
            exp_q.delete();
            check("abort_rd_valid", RW'(rd_valid), 0);
            check("abort_rd_last", RW'(rd_last), 0);
            check("abort_busy", RW'(busy), 0);
            check("abort_ld_done", RW'(ld_done), 0);
            rd_ready = 1'b0;
            return;
         end
         if (acc_n == stall_at && stall_left > 0 && rd_valid) begin
            rd_ready = 1'b0;
            stall_left--;
         end else begin
            rd_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         acc = rd_valid && rd_ready;
         tick;
         cyc++;
         if (acc) acc_n++;
      end
      rd_ready = 1'b0;
      if (acc_n < D) begin
         checks++;
         errors++;
         $display("FAIL replay_timeout: got %0d beats expected %0d", acc_n, D);
      end
      check("replay_end_busy", RW'(busy), 0);
      check("replay_end_valid", RW'(rd_valid), 0);
      check("replay_queue_drained", RW'(exp_q.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin
      rst      = 1'b1;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_data  = '0;
      rd_start = 1'b0;
      rd_ready = 1'b0;
      tick;
      tick;
      check("reset_ld_ready", RW'(ld_ready), 0);
      check("reset_ld_done", RW'(ld_done), 0);
      check("reset_rd_valid", RW'(rd_valid), 0);
      check("reset_rd_last", RW'(rd_last), 0);
      check("reset_rd_data", rd_data, 0);
      check("reset_busy", RW'(busy), 0);
      rst = 1'b0;
      tick;

      // Replay request with nothing loaded is dropped.
      rd_start = 1'b1;
      tick;
      rd_start = 1'b0;
      check("unloaded_rd_start_busy", RW'(busy), 0);
      tick;
      check("unloaded_rd_start_valid", RW'(rd_valid), 0);

      do_load(1'b0);
      do_replay(-1, 0, -1, 1'b0);
      do_replay(3, 5, -1, 1'b0);

      // ld_start beats rd_start; rd_start during LOAD is ignored; restart mid-load.
      ld_start = 1'b1;
      rd_start = 1'b1;
      tick;
      ld_start = 1'b0;
      check("collide_ld_ready", RW'(ld_ready), 1);
      check("collide_ld_done", RW'(ld_done), 0);
      tick;
      check("load_rd_start_ignored", RW'(ld_ready), 1);
      check("load_rd_start_no_valid", RW'(rd_valid), 0);
      rd_start = 1'b0;
      ld_valid = 1'b1;
      ld_data  = 16'hFFFF;
      repeat (3) tick;
      ld_valid = 1'b0;
      do_load(1'b1);
      do_replay(-1, 0, -1, 1'b1);
      do_replay(2, 3, -1, 1'b1);

      do_load(1'b0);
      do_replay(-1, 0, 4, 1'b0);
      do_load(1'b0);
      do_replay(-1, 0, -1, 1'b0);

      repeat (3) tick;
      check("final_queue_empty", RW'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
